// File: rtl/instr_sequencer.sv
// instr_sequencer
// Issues a preloaded program of 16-bit instructions to the control unit one
// word at a time. Each word stays on the bus for as many cycles as its opcode
// needs.
//
// Opcodes: 000 NOP and 001 LOAD_ADDR are held 1 cycle. 010 LOAD_WEIGHT and
// 011 LOAD_INPUTS are held LOAD_CYCLES cycles. 100 VALID is held until
// compute_done. 111 HALT ends the program and is never driven. 101 and 110
// are illegal.
//
// Ports:
//   clk           clock, all state on rising edge
//   reset         asynchronous reset, active low
//   prog_we       push prog_data into the program FIFO
//   prog_data     instruction word, [15:13] opcode, [12:0] operand
//   prog_full     FIFO full
//   prog_count    FIFO occupancy
//   start         begin issuing (honoured only when idle)
//   compute_done  array finished the current compute
//   instruction   registered instruction to the control unit
//   busy          high whenever not idle
//   done          one-cycle pulse at program end
//   error         sticky: illegal opcode or write while full; start clears it
//
// State   | meaning
// --------+---------------------------------------------------------------
// IDLE    | bus at 0, waiting for start
// ISSUE   | single-cycle word on the bus
// HOLD    | load word on the bus, hold counter counting down to 0
// WAIT    | compute word on the bus until compute_done
// FINISH  | bus at 0, done pulse, back to IDLE next cycle
module instr_sequencer #(
    parameter int DEPTH       = 16,
    parameter int LOAD_CYCLES = 4,
    parameter int CW          = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [15:0]   prog_data,
    output logic          prog_full,
    output logic [CW-1:0] prog_count,
    input  logic          start,
    input  logic          compute_done,
    output logic [15:0]   instruction,
    output logic          busy,
    output logic          done,
    output logic          error
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_HOLD,
        S_WAIT,
        S_FINISH
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic [HW-1:0]  hold_q, hold_d;
    logic [15:0]    instr_d;
    logic [15:0]    head;
    logic           fifo_empty, push, pop, word_end;
    logic           err_set, err_clr;

    assign fifo_empty = (count == '0);
    assign prog_full  = (count == CW'(DEPTH));
    assign prog_count = count;
    assign push       = prog_we & ~prog_full;
    assign head       = mem[rd_ptr];
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_FINISH);

    // Storage is not reset; occupancy and pointers alone define the contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= prog_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        instr_d  = instruction;
        hold_d   = hold_q;
        pop      = 1'b0;
        word_end = 1'b0;
        err_set  = prog_we & prog_full;
        err_clr  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_clr = 1'b1;
                    if (fifo_empty) state_d = S_FINISH;
                    else            pop = 1'b1;
                end
            end
            S_ISSUE: word_end = 1'b1;
            S_HOLD: begin
                if (hold_q == '0) word_end = 1'b1;
                else              hold_d = hold_q - HW'(1);
            end
            S_WAIT:   word_end = compute_done;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Popping on the same edge that ends a hold gives gap-free issue.
        if (word_end) begin
            if (fifo_empty) begin
                instr_d = 16'h0000;
                state_d = S_FINISH;
            end else begin
                pop = 1'b1;
            end
        end

        if (pop) begin
            instr_d = head;
            case (head[15:13])
                3'b000, 3'b001: state_d = S_ISSUE;
                3'b010, 3'b011: begin
                    hold_d  = HW'(LOAD_CYCLES - 1);
                    state_d = S_HOLD;
                end
                3'b100: state_d = S_WAIT;
                3'b111: begin
                    instr_d = 16'h0000;
                    state_d = S_FINISH;
                end
                default: begin
                    instr_d = 16'h0000;
                    err_set = 1'b1;
                    state_d = S_FINISH;
                end
            endcase
        end
    end

    // A new error event wins over the clear from start in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            instruction <= 16'h0000;
            hold_q      <= '0;
            error       <= 1'b0;
        end else begin
            state_q     <= state_d;
            instruction <= instr_d;
            hold_q      <= hold_d;
            if (err_set)      error <= 1'b1;
            else if (err_clr) error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

    localparam int DEPTH       = 16;
    localparam int LOAD_CYCLES = 4;
    localparam int CW          = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          prog_we = 1'b0;
    logic [15:0]   prog_data = 16'h0000;
    logic          prog_full;
    logic [CW-1:0] prog_count;
    logic          start = 1'b0;
    logic          compute_done = 1'b0;
    logic [15:0]   instruction;
    logic          busy, done, error;

    int total = 0;
    int bad   = 0;

    instr_sequencer #(.DEPTH(DEPTH), .LOAD_CYCLES(LOAD_CYCLES)) dut (
        .clk(clk), .reset(reset),
        .prog_we(prog_we), .prog_data(prog_data),
        .prog_full(prog_full), .prog_count(prog_count),
        .start(start), .compute_done(compute_done),
        .instruction(instruction),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Reference model: program queue plus the word currently on the bus.
    // phase 0 = idle, 1 = a word is on the bus, 2 = the done cycle.
    logic [15:0] q[$];
    logic [15:0] m_instr;
    int          m_phase;
    int          m_left;
    bit          m_wait;
    bit          m_err;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("instruction", instruction, m_instr);
        chk("busy", 16'(busy), 16'(m_phase != 0));
        chk("done", 16'(done), 16'(m_phase == 2));
        chk("error", 16'(error), 16'(m_err));
        chk("prog_count", 16'(prog_count), 16'(q.size()));
        chk("prog_full", 16'(prog_full), 16'(q.size() == DEPTH));
    endtask

    task automatic model_reset();
        q.delete();
        m_instr = 16'h0000;
        m_phase = 0;
        m_left  = 0;
        m_wait  = 0;
        m_err   = 0;
    endtask

    task automatic model_step(input bit we, input logic [15:0] data, input bit st, input bit cd);
        int         sz;
        bit         take;
        bit         ends;
        logic [15:0] w;
        int         op;
        sz   = q.size();
        take = 0;
        ends = 0;
        if (m_phase == 0) begin
            if (st) begin
                m_err = 0;
                if (sz > 0) take = 1;
                else        m_phase = 2;
            end
        end else if (m_phase == 1) begin
            if (m_wait)           ends = cd;
            else if (m_left == 1) ends = 1;
            else                  m_left--;
            if (ends) begin
                if (sz > 0) take = 1;
                else begin
                    m_instr = 16'h0000;
                    m_phase = 2;
                end
            end
        end else begin
            m_phase = 0;
        end
        if (take) begin
            w      = q.pop_front();
            op     = int'(w[15:13]);
            m_wait = 0;
            if (op <= 1) begin
                m_instr = w; m_left = 1; m_phase = 1;
            end else if (op <= 3) begin
                m_instr = w; m_left = LOAD_CYCLES; m_phase = 1;
            end else if (op == 4) begin
                m_instr = w; m_wait = 1; m_phase = 1;
            end else if (op == 7) begin
                m_instr = 16'h0000; m_phase = 2;
            end else begin
                m_instr = 16'h0000; m_err = 1; m_phase = 2;
            end
        end
        if (we) begin
            if (sz < DEPTH) q.push_back(data);
            else            m_err = 1;
        end
    endtask

    task automatic cyc(input bit we, input logic [15:0] data, input bit st, input bit cd);
        @(negedge clk);
        prog_we      = we;
        prog_data    = data;
        start        = st;
        compute_done = cd;
        @(posedge clk);
        model_step(we, data, st, cd);
        #1;
        check_all();
    endtask

    task automatic push(input logic [15:0] w);
        cyc(1'b1, w, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        prog_we      = 1'b0;
        prog_data    = 16'h0000;
        start        = 1'b0;
        compute_done = 1'b0;
        reset        = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [15:0] rand_word();
        logic [2:0] op;
        int r;
        r = int'($urandom_range(0, 15));
        if (r <= 2)       op = 3'b000;
        else if (r <= 4)  op = 3'b001;
        else if (r <= 7)  op = 3'b010;
        else if (r <= 10) op = 3'b011;
        else if (r <= 13) op = 3'b100;
        else if (r == 14) op = 3'b111;
        else              op = ($urandom_range(0, 1) == 0) ? 3'b101 : 3'b110;
        return {op, 13'($urandom)};
    endfunction

    initial begin
        do_reset();

        // Mixed program, compute word released by compute_done.
        push(16'h2005); push(16'h4000); push(16'h6000); push(16'h8000);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        idle(14);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1);
        idle(3);

        // HALT ends the program and leaves later words queued.
        push(16'h2001); push(16'hE000); push(16'h2002);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        idle(4);
        do_reset();

        // Illegal opcode, then a start that clears the error.
        push(16'hA000);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        idle(3);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        idle(2);

        // Overflow, then pushes that coincide with pops.
        for (int i = 0; i <= DEPTH; i++) push(16'(i));
        idle(1);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) push(16'h2100 + 16'(i));
        idle(DEPTH + 4);

        // Empty start, and start held during a compute wait.
        do_reset();
        cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        idle(2);
        push(16'h8123);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        cyc(1'b0, 16'h0000, 1'b1, 1'b1);
        idle(3);

        // Reset in the middle of a hold, then a fresh program.
        push(16'h4000); push(16'h2003);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        idle(2);
        do_reset();
        push(16'h2007); push(16'h0042);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        idle(4);

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cyc(($urandom_range(0, 99) < 35), rand_word(),
                    ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 20));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Issue-side counterpart of the instruction decoder. A host preloads a program of 16-bit instructions into an internal FIFO, then pulses start. The block then drives them one at a time onto the decoder's instruction bus, holding each word for the cycles its opcode needs. It sits between the host/config interface and the control unit; its instruction output feeds the control unit's instruction input directly.

Parameters:
DEPTH, 16, program FIFO entries; power of 2, at least 2
LOAD_CYCLES, 4, cycles a LOAD_WEIGHT or LOAD_INPUTS word is held on the bus; at least 1
CW, $clog2(DEPTH+1), width of prog_count

Ports:
clk  in  1  clock; all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
prog_we  in  1  push prog_data into the FIFO
prog_data  in  16  instruction word: [15:13] opcode, [12:0] operand
prog_full  out  1  FIFO full
prog_count  out  CW  FIFO occupancy
start  in  1  begin issuing; honoured only in IDLE
compute_done  in  1  array finished the current compute
instruction  out  16  registered instruction driven to the control unit
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when program ends
error  out  1  sticky; illegal opcode or write while full

Behaviour:
- Opcodes:
  - 000 NOP: held 1 cycle.
  - 001 LOAD_ADDR: held 1 cycle.
  - 010 LOAD_WEIGHT: held LOAD_CYCLES cycles.
  - 011 LOAD_INPUTS: held LOAD_CYCLES cycles.
  - 100 VALID/compute: held until compute_done sampled 1.
  - 111 HALT: never driven; ends the program.
  - 101 and 110: illegal.
- Reset (reset=0, async): FIFO empty, state IDLE. instruction=16'h0000, busy=0, done=0, error=0, prog_full=0, prog_count=0. Reset mid-program aborts immediately and discards all FIFO contents.
- FIFO: first-word-fall-through.
  - Push when prog_we=1 and not full.
  - prog_we while full: word dropped, error set.
  - Simultaneous push and pop: both occur, count unchanged.
  - Pointers wrap modulo DEPTH.
  - Writes are accepted in any state, including mid-program.
- States: IDLE, ISSUE, HOLD, WAIT_COMPUTE, FINISH.
- IDLE: instruction=0.
  - start=1 and FIFO non-empty: pop head into the instruction register and go to ISSUE. The word is visible on instruction the cycle after start.
  - start=1 and FIFO empty: go to FINISH.
  - start also clears error.
- Issue latch (same edge as the pop), by opcode of the popped word:
  - 000/001: go to ISSUE; the word is held 1 cycle.
  - 010/011: load hold counter with LOAD_CYCLES-1 and go to HOLD.
  - 100: go to WAIT_COMPUTE.
  - 111: instruction=0, go to FINISH; HALT never appears on the bus.
  - 101/110: instruction=0, error=1, go to FINISH.
- End of a word's hold: at the edge where the hold completes, if the FIFO is non-empty, pop the next word into instruction. This gives back-to-back issue with no gap. If the FIFO is empty, instruction=0 and go to FINISH.
- HOLD: counter decrements each cycle; the hold ends when the counter is 0.
- WAIT_COMPUTE:
  - Word held indefinitely; the hold ends on the cycle compute_done=1.
  - compute_done is ignored in all other states.
  - There is no timeout.
- FINISH: instruction=0 and done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored.
- busy=1 in ISSUE, HOLD, WAIT_COMPUTE and FINISH.
- Operand bits [12:0] pass through unmodified; the sequencer inspects only [15:13].
- instruction is always registered (glitch-free). It returns to 16'h0000 between programs so the decoder sits on its default path.

Test Plan:
- Reset, then push 0x2005, 0x4000, 0x6000, 0x8000, then start -> instruction = 0x2005 for 1 cycle, 0x4000 for 4, 0x6000 for 4, then 0x8000 held until compute_done is pulsed; then done pulses once, instruction=0, busy=0, prog_count=0.
- Push 0x2001, 0xE000 (HALT), 0x2002, then start -> 0x2001 for 1 cycle, done pulse, 0x2002 never driven, prog_count=1 remains.
- Push 0xA000 then start -> instruction stays 0, error=1, done pulses; a subsequent start clears error.
- Push DEPTH+1 words with no start -> prog_full=1 after DEPTH writes, extra word dropped, error=1, prog_count=DEPTH. Same-cycle push and pop during a run -> count unchanged.
- Start with empty FIFO -> done pulse next cycle, busy high one cycle. start held high while in WAIT_COMPUTE -> no effect.
- Assert reset (0) mid-HOLD on 0x4000 -> instruction=0, busy=0, prog_count=0 asynchronously. After release, a new program runs from its first word.
